// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
//
// Shared definitions for the instruction-memory access controller and the
// logic around it (IF stage, test benches).
//
// Contents:
//   IMEM_ADDR_W / IMEM_DATA_W  default word-address and instruction widths
//   IMEM_NOP                   instruction encoding used as a bubble
//   imem_state_e               run-sequencer states (LOAD, CLEAR, RUN)
//   WAIT_CNT_W                 width of the host starvation counter
//   sat_inc_wait()             saturating increment for that counter
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W = 8;
  localparam int unsigned IMEM_DATA_W = 32;

  // All-zero word doubles as the pipeline bubble.
  localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

  // LOAD is the reset state: the host owns the memory port.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } imem_state_e;

  localparam int unsigned WAIT_CNT_W = 4;

  // Saturating increment: the counter parks at all-ones instead of wrapping,
  // so a long-starved host never looks freshly arrived.
  function automatic logic [WAIT_CNT_W-1:0] sat_inc_wait(
    input logic [WAIT_CNT_W-1:0] value
  );
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage : imem_pkg

// File: rtl/imem_starve_ctr.sv
// -----------------------------------------------------------------------------
// imem_starve_ctr
//
// Counts consecutive cycles in which a pending host write was refused while
// the core was running, and flags when that count has reached the preemption
// threshold. The controller turns the flag into a fetch-stealing write.
//
// Parameters:
//   THRESHOLD   denied cycles before at_limit asserts (1..15)
//
// Ports:
//   clk         clock, all state on posedge
//   rst         synchronous active-high reset, clears the count
//   denied      this cycle a host write was pending in RUN and not accepted;
//               any cycle without it (accepted, idle host, not in RUN) clears
//               the count
//   at_limit    count has reached THRESHOLD
// -----------------------------------------------------------------------------
module imem_starve_ctr
  import imem_pkg::*;
#(
  parameter int unsigned THRESHOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic denied,
  output logic at_limit
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(THRESHOLD);

  logic [WAIT_CNT_W-1:0] wait_cnt_q;

  // NOTE: registered state is always written with non-blocking assignments so
  // every flop samples the pre-edge values of the others, independent of
  // process ordering in simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (denied) begin
      wait_cnt_q <= sat_inc_wait(wait_cnt_q);
    end else begin
      wait_cnt_q <= '0;
    end
  end

  assign at_limit = (wait_cnt_q >= LIMIT);

endmodule : imem_starve_ctr

// File: rtl/imem_ctrl.sv
// -----------------------------------------------------------------------------
// imem_ctrl
//
// Access controller and run sequencer for the single-port instruction memory
// of the 5-stage pipeline. The one memory port is shared between the IF-stage
// fetch path and the host program loader. The sequencer walks the core through
// LOAD (host writes the program), CLEAR (one cycle of PC clear) and RUN
// (fetching), and drives the stall / PC-clear controls seen by the PC register.
//
// Build option:
//   IMEM_CTRL_RUN_WRITE_EN  when defined, the host may also write while the
//                           core runs: fetch has priority, but a host denied
//                           MAX_HOST_WAIT consecutive cycles steals one cycle
//                           (fetch held off, pipeline stalled). When undefined
//                           the host may only write in LOAD and RUN never
//                           stalls.
//
// Parameters:
//   ADDR_W          word-address width
//   DATA_W          instruction width
//   MAX_HOST_WAIT   denied cycles before a host write preempts fetch (1..15)
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   host_wr_valid/ready       host write handshake (accepted on valid&ready)
//   host_addr, host_wdata     host write address / data
//   host_start, host_halt     pulses: begin execution / return to LOAD
//   fetch_req, fetch_addr     IF-stage read request at the PC
//   fetch_gnt                 fetch read issued this cycle
//   fetch_rvalid, fetch_rdata read data, one cycle after fetch_gnt
//   mem_en, mem_we            memory enable / write enable
//   mem_addr, mem_wdata       memory address / write data
//   mem_rdata                 memory read data (1-cycle synchronous read)
//   pipe_stall                hold PC and all pipeline registers
//   pc_clear                  force PC to 0 at the next edge
//   running                   sequencer is in RUN
// -----------------------------------------------------------------------------
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W        = IMEM_ADDR_W,
  parameter int unsigned DATA_W        = IMEM_DATA_W,
  parameter int unsigned MAX_HOST_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // host loader
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_start,
  input  logic              host_halt,
  // IF stage
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  // instruction memory
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // pipeline control
  output logic              pipe_stall,
  output logic              pc_clear,
  output logic              running
);

  if (MAX_HOST_WAIT < 1 || MAX_HOST_WAIT > 15) begin : g_bad_wait
    $error("imem_ctrl: MAX_HOST_WAIT must be in 1..15");
  end

  imem_state_e state_q;
  imem_state_e state_d;
  logic        rvalid_q;
  logic        wr_fire;
  logic        steal;

  // ---------------------------------------------------------------------------
  // Host starvation tracking (only when writes are allowed during RUN)
  // ---------------------------------------------------------------------------
`ifdef IMEM_CTRL_RUN_WRITE_EN
  logic at_limit;
  logic denied;

  // A refused write in RUN keeps the count going; anything else restarts it.
  assign denied = (state_q == RUN) && host_wr_valid && !host_wr_ready && !rst;

  imem_starve_ctr #(
    .THRESHOLD (MAX_HOST_WAIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .denied   (denied),
    .at_limit (at_limit)
  );

  // Stealing only matters when fetch actually wants the port; with fetch idle
  // the write goes through as an ordinary cycle without stalling the core.
  assign steal = (state_q == RUN) && host_wr_valid && fetch_req && at_limit;
`else
  assign steal = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: next state. Halt always wins over start; start outside LOAD and
  // halt inside LOAD are ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      LOAD: begin
        if (host_start && !host_halt) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = host_halt ? LOAD : RUN;
      end
      RUN: begin
        if (host_halt) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer: outputs. Reset overrides everything so the pipeline is held and
  // the memory idle for as long as rst is high, whatever state_q holds.
  // ---------------------------------------------------------------------------
  always_comb begin
    host_wr_ready = 1'b0;
    fetch_gnt     = 1'b0;
    pipe_stall    = 1'b1;
    pc_clear      = 1'b0;
    running       = 1'b0;
    if (!rst) begin
      unique case (state_q)
        LOAD: begin
          host_wr_ready = 1'b1;
        end
        CLEAR: begin
          pc_clear = 1'b1;
        end
        RUN: begin
          running = 1'b1;
`ifdef IMEM_CTRL_RUN_WRITE_EN
          host_wr_ready = !fetch_req || steal;
          fetch_gnt     = fetch_req && !steal;
          pipe_stall    = steal;
`else
          fetch_gnt     = fetch_req;
          pipe_stall    = 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory port mux. host_wr_ready and fetch_gnt are never both set in one
  // cycle, so a write and a fetch cannot collide on the port.
  // ---------------------------------------------------------------------------
  assign wr_fire   = host_wr_valid && host_wr_ready;
  assign mem_en    = wr_fire || fetch_gnt;
  assign mem_we    = wr_fire;
  assign mem_addr  = wr_fire ? host_addr : fetch_addr;
  assign mem_wdata = host_wdata;

  // ---------------------------------------------------------------------------
  // Read return: data comes straight from the synchronous memory, valid one
  // cycle after the grant. Reset also masks the output so a read in flight
  // when reset arrives is dropped immediately.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= fetch_gnt;
    end
  end

  assign fetch_rvalid = rvalid_q && !rst;
  assign fetch_rdata  = mem_rdata;

endmodule : imem_ctrl

// File: tb/tb_imem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_ctrl
//
// Directed bench for imem_ctrl. A behavioural model of the access rules runs
// beside the DUT and is compared against every output on every cycle; the
// directed sequence also pins a set of hand-computed literal values.
// Honours IMEM_CTRL_RUN_WRITE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_imem_ctrl;

  localparam int unsigned ADDR_W        = 8;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned MAX_HOST_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              host_wr_valid;
  logic              host_wr_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_start;
  logic              host_halt;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [DATA_W-1:0] fetch_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              pipe_stall;
  logic              pc_clear;
  logic              running;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imem_ctrl #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .MAX_HOST_WAIT (MAX_HOST_WAIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .host_wr_valid (host_wr_valid),
    .host_wr_ready (host_wr_ready),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_start    (host_start),
    .host_halt     (host_halt),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_gnt     (fetch_gnt),
    .fetch_rvalid  (fetch_rvalid),
    .fetch_rdata   (fetch_rdata),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .pipe_stall    (pipe_stall),
    .pc_clear      (pc_clear),
    .running       (running)
  );

  // ---------------------------------------------------------------------------
  // Instruction memory the DUT drives: 256x32, 1-cycle synchronous read.
  // Unwritten words hold a recognisable address pattern.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] env_mem [256];

  initial begin
    for (int i = 0; i < 256; i++) env_mem[i] = 32'hDEAD_0000 | i;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr] = mem_wdata;
      else        mem_rdata <= env_mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: phase of the run sequence, how long the host has been
  // refused, the expected memory image and the read owed to the IF stage.
  // ---------------------------------------------------------------------------
  localparam int PH_LOAD  = 0;
  localparam int PH_CLEAR = 1;
  localparam int PH_RUN   = 2;

  int                m_phase   = PH_LOAD;
  int                m_refused = 0;
  bit                m_owed    = 1'b0;
  logic [DATA_W-1:0] m_owed_data;
  logic [DATA_W-1:0] m_mem [256];

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 32'hDEAD_0000 | i;
  end

  always @(negedge clk) begin
    bit e_ready, e_gnt, e_stall, e_clear, e_run, e_wr, e_steal;
    e_ready = 1'b0; e_gnt = 1'b0; e_stall = 1'b1;
    e_clear = 1'b0; e_run = 1'b0; e_steal = 1'b0;
    if (!rst) begin
      if (m_phase == PH_LOAD) begin
        e_ready = 1'b1;
      end else if (m_phase == PH_CLEAR) begin
        e_clear = 1'b1;
      end else begin
        e_run = 1'b1;
`ifdef IMEM_CTRL_RUN_WRITE_EN
        e_steal = host_wr_valid && fetch_req && (m_refused >= MAX_HOST_WAIT);
        e_ready = !fetch_req || e_steal;
        e_gnt   = fetch_req && !e_steal;
        e_stall = e_steal;
`else
        e_gnt   = fetch_req;
        e_stall = 1'b0;
`endif
      end
    end
    e_wr = host_wr_valid && e_ready;

    check("running",       running,       e_run);
    check("pc_clear",      pc_clear,      e_clear);
    check("pipe_stall",    pipe_stall,    e_stall);
    check("host_wr_ready", host_wr_ready, e_ready);
    check("fetch_gnt",     fetch_gnt,     e_gnt);
    check("mem_en",        mem_en,        e_wr || e_gnt);
    check("mem_we",        mem_we,        e_wr);
    check("fetch_rvalid",  fetch_rvalid,  !rst && m_owed);
    if (e_wr) begin
      check("mem_addr_wr", mem_addr,  host_addr);
      check("mem_wdata",   mem_wdata, host_wdata);
    end
    if (e_gnt) check("mem_addr_rd", mem_addr, fetch_addr);
    if (!rst && m_owed) check("fetch_rdata", fetch_rdata, m_owed_data);

    // advance the model to the next cycle
    if (rst) begin
      m_phase   = PH_LOAD;
      m_refused = 0;
      m_owed    = 1'b0;
    end else begin
      if (e_wr) m_mem[host_addr] = host_wdata;
      m_owed = e_gnt;
      if (e_gnt) m_owed_data = m_mem[fetch_addr];
      if (m_phase == PH_RUN && host_wr_valid && !e_ready)
        m_refused = (m_refused < 15) ? m_refused + 1 : 15;
      else
        m_refused = 0;
      if (m_phase == PH_LOAD) begin
        if (host_start && !host_halt) m_phase = PH_CLEAR;
      end else if (m_phase == PH_CLEAR) begin
        m_phase = host_halt ? PH_LOAD : PH_RUN;
      end else if (host_halt) begin
        m_phase = PH_LOAD;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus. Inputs change 1 time unit after a rising edge; literal
  // checks sample on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [31:0] d);
    host_wr_valid = 1'b1;
    host_addr     = a;
    host_wdata    = d;
    @(negedge clk);
    check("lit_load_ready", host_wr_ready, 1'b1);
    check("lit_load_we",    mem_we,        1'b1);
    check("lit_load_gnt",   fetch_gnt,     1'b0);
    check("lit_load_stall", pipe_stall,    1'b1);
    next_cycle();
    host_wr_valid = 1'b0;
  endtask

  // host_start from LOAD: one CLEAR cycle with pc_clear, then RUN.
  task automatic start_core();
    host_start = 1'b1;
    @(negedge clk);
    check("lit_start_noclr", pc_clear, 1'b0);
    next_cycle();
    host_start = 1'b0;
    @(negedge clk);
    check("lit_clear_pc", pc_clear, 1'b1);
    check("lit_clear_run", running, 1'b0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; host_wr_valid = 1'b0; host_addr = '0; host_wdata = '0;
    host_start = 1'b0; host_halt = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("lit_rst_stall",  pipe_stall,    1'b1);
    check("lit_rst_ready",  host_wr_ready, 1'b0);
    check("lit_rst_rvalid", fetch_rvalid,  1'b0);
    next_cycle();
    rst = 1'b0;

    // program load
    host_write(8'd0, 32'hA);
    host_write(8'd1, 32'hB);
    host_write(8'd2, 32'hC);

    // start, first fetch of address 1
    start_core();
    fetch_req = 1'b1; fetch_addr = 8'd1;
    @(negedge clk);
    check("lit_run_running", running,   1'b1);
    check("lit_run_gnt",     fetch_gnt, 1'b1);
    next_cycle();
    fetch_req = 1'b0;
    @(negedge clk);
    check("lit_first_rvalid", fetch_rvalid, 1'b1);
    check("lit_first_rdata",  fetch_rdata,  32'hB);
    next_cycle();

    // host write pending under continuous fetch
    for (int k = 0; k < 10; k++) begin
      fetch_req = 1'b1; fetch_addr = 8'h10 + 8'(k);
      host_wr_valid = 1'b1; host_addr = 8'h20; host_wdata = 32'h1234_5678;
      @(negedge clk);
`ifdef IMEM_CTRL_RUN_WRITE_EN
      check("lit_steal_ready", host_wr_ready, (k == 4 || k == 9));
      check("lit_steal_stall", pipe_stall,    (k == 4 || k == 9));
      check("lit_steal_gnt",   fetch_gnt,     !(k == 4 || k == 9));
`else
      check("lit_run_noready", host_wr_ready, 1'b0);
      check("lit_run_nostall", pipe_stall,    1'b0);
`endif
      next_cycle();
    end
    host_wr_valid = 1'b0;
    fetch_addr = 8'h20;
    @(negedge clk);
    next_cycle();
    fetch_req = 1'b0;
    @(negedge clk);
`ifdef IMEM_CTRL_RUN_WRITE_EN
    check("lit_stolen_data", fetch_rdata, 32'h1234_5678);
`else
    check("lit_unwritten",   fetch_rdata, 32'hDEAD_0020);
`endif
    next_cycle();

    // halt coincident with a granted fetch
    fetch_req = 1'b1; fetch_addr = 8'd2; host_halt = 1'b1;
    @(negedge clk);
    check("lit_halt_gnt", fetch_gnt, 1'b1);
    next_cycle();
    fetch_req = 1'b0; host_halt = 1'b0;
    @(negedge clk);
    check("lit_halt_load",   running,       1'b0);
    check("lit_halt_ready",  host_wr_ready, 1'b1);
    check("lit_halt_rvalid", fetch_rvalid,  1'b1);
    check("lit_halt_rdata",  fetch_rdata,   32'hC);
    next_cycle();

    // start and halt together in LOAD: stay in LOAD
    host_start = 1'b1; host_halt = 1'b1;
    @(negedge clk);
    next_cycle();
    host_start = 1'b0; host_halt = 1'b0;
    @(negedge clk);
    check("lit_both_noclr", pc_clear, 1'b0);
    check("lit_both_norun", running,  1'b0);
    next_cycle();
    @(negedge clk);
    check("lit_both_load", running, 1'b0);
    next_cycle();

    // address wrap 8'hFF -> 8'h00 on back-to-back fetches
    host_write(8'hFF, 32'hFFFF_0001);
    host_write(8'h00, 32'h0000_0F00);
    start_core();
    fetch_req = 1'b1; fetch_addr = 8'hFF;
    @(negedge clk);
    check("lit_wrap_gnt_ff", fetch_gnt, 1'b1);
    next_cycle();
    fetch_addr = 8'h00;
    @(negedge clk);
    check("lit_wrap_gnt_00", fetch_gnt,   1'b1);
    check("lit_wrap_rd_ff",  fetch_rdata, 32'hFFFF_0001);
    next_cycle();
    fetch_req = 1'b0;
    @(negedge clk);
    check("lit_wrap_rd_00", fetch_rdata, 32'h0000_0F00);
    next_cycle();

    // reset mid-RUN with a read in flight
    fetch_req = 1'b1; fetch_addr = 8'd1;
    @(negedge clk);
    check("lit_pre_rst_gnt", fetch_gnt, 1'b1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("lit_rst_drop",     fetch_rvalid, 1'b0);
    check("lit_rst_gnt_off",  fetch_gnt,    1'b0);
    check("lit_rst_run_off",  running,      1'b0);
    next_cycle();
    rst = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    check("lit_post_rst_rvalid", fetch_rvalid, 1'b0);
    check("lit_post_rst_load",   running,      1'b0);
    check("lit_post_rst_stall",  pipe_stall,   1'b1);
    next_cycle();
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_imem_ctrl
